// File: rtl/ghost_dir_select_pkg.sv
// ============================================================================
//  Package    : ghost_pkg
//  Description: Shared direction encoding, maze geometry constants and the
//               direction-reverse helper for the ghost decision logic.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package ghost_pkg;

  // Encoding chosen so that the opposite direction is always dir ^ 2'b10
  typedef enum logic [1:0] {
    DIR_U = 2'd0,
    DIR_L = 2'd1,
    DIR_D = 2'd2,
    DIR_R = 2'd3
  } dir_t;

  localparam int COORD_W     = 5;
  localparam int DIST_W      = 11;
  localparam int MAZE_ADDR_W = 2 * COORD_W;

  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ghost_dir_select_tile_neighbour.sv
// ============================================================================
//  Module     : tile_neighbour
//  Description: Combinational neighbour-tile address generator. Given a tile
//               (x, y) and a direction, returns the {y, x} address of the
//               adjacent tile with modulo wrap so maze tunnels connect.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_neighbour #(
  parameter int COORD_W = 5
) (
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic [1:0]           dir,
  output logic [2*COORD_W-1:0] addr
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;

  // Step one tile in the requested direction; natural overflow gives the wrap
  always_comb begin
    nx = x;
    ny = y;
    case (dir)
      ghost_pkg::DIR_U: ny = y - ONE;
      ghost_pkg::DIR_D: ny = y + ONE;
      ghost_pkg::DIR_L: nx = x - ONE;
      ghost_pkg::DIR_R: nx = x + ONE;
      default: ;
    endcase
  end

  assign addr = {ny, nx};

endmodule

`default_nettype wire

// File: rtl/ghost_dir_select.sv
// ============================================================================
//  Module     : ghost_dir_select
//  Description: Per-ghost decision stage. Latches the four neighbour distances
//               on start, reads the wall bit of each neighbour tile (U, L, D,
//               R), drops walls and the reverse heading, and commits the
//               minimum-distance legal direction with a one-cycle done pulse.
//               Optional build macro GHOST_FRIGHT_RAND_EN adds an 8-bit LFSR
//               that picks a random legal direction while frightened.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghost_dir_select #(
  parameter int DIST_W  = 11,
  parameter int COORD_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [COORD_W-1:0]   x_pos,
  input  logic [COORD_W-1:0]   y_pos,
  input  logic [1:0]           cur_dir,
  input  logic [DIST_W-1:0]    r_dist,
  input  logic [DIST_W-1:0]    l_dist,
  input  logic [DIST_W-1:0]    u_dist,
  input  logic [DIST_W-1:0]    d_dist,
  input  logic                 fright,
  output logic                 wall_rd,
  output logic [2*COORD_W-1:0] wall_addr,
  input  logic                 wall_data,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           next_dir
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state;
  logic [1:0]           idx;
  logic [COORD_W-1:0]   x_q;
  logic [COORD_W-1:0]   y_q;
  logic [1:0]           dir_q;
  logic [DIST_W-1:0]    dist_q [4];

  logic                 best_valid;
  logic [1:0]           best_dir;
  logic [DIST_W-1:0]    best_key;

  logic [COORD_W-1:0]   nb_x;
  logic [COORD_W-1:0]   nb_y;
  logic [1:0]           nb_dir;
  logic [2*COORD_W-1:0] nb_addr;

  logic [1:0]           rev_dir;
  logic [1:0]           cand;
  logic [DIST_W-1:0]    cand_key;
  logic                 cand_take;
  logic [1:0]           final_dir;

`ifdef GHOST_FRIGHT_RAND_EN
  logic [7:0]           lfsr;
  logic                 fright_q;
  logic [1:0]           start_q;
  logic [1:0]           rank;

  // Free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Cyclic distance from the random starting candidate; smaller rank wins
  assign rank = cand - start_q;
`else
  logic unused_fright;
  assign unused_fright = fright;
`endif

  // In IDLE the first (U) address is built from the live inputs so it can be
  // registered on the start edge; afterwards the latched tile is used.
  always_comb begin
    nb_x   = x_q;
    nb_y   = y_q;
    nb_dir = idx + 2'd1;
    if (state == S_IDLE) begin
      nb_x   = x_pos;
      nb_y   = y_pos;
      nb_dir = ghost_pkg::DIR_U;
    end
  end

  tile_neighbour #(
    .COORD_W (COORD_W)
  ) u_tile_neighbour (
    .x    (nb_x),
    .y    (nb_y),
    .dir  (nb_dir),
    .addr (nb_addr)
  );

  assign rev_dir = ghost_pkg::dir_reverse(ghost_pkg::dir_t'(dir_q));

  // Candidate under evaluation lags the read by one cycle (wall_data latency)
  always_comb begin
    cand     = (state == S_LAST) ? 2'd3 : (idx - 2'd1);
    cand_key = dist_q[cand];
`ifdef GHOST_FRIGHT_RAND_EN
    if (fright_q) begin
      cand_key = {{(DIST_W-2){1'b0}}, rank};
    end
`endif
    cand_take = !wall_data && (cand != rev_dir) &&
                (!best_valid || (cand_key < best_key));
    if (cand_take) begin
      final_dir = cand;
    end else if (best_valid) begin
      final_dir = best_dir;
    end else begin
      final_dir = rev_dir;
    end
  end

  // Control FSM with registered strobes, address and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      x_q        <= '0;
      y_q        <= '0;
      dir_q      <= 2'd0;
      dist_q[0]  <= '0;
      dist_q[1]  <= '0;
      dist_q[2]  <= '0;
      dist_q[3]  <= '0;
      best_valid <= 1'b0;
      best_dir   <= 2'd0;
      best_key   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wall_rd    <= 1'b0;
      wall_addr  <= '0;
      next_dir   <= ghost_pkg::DIR_L;
`ifdef GHOST_FRIGHT_RAND_EN
      fright_q   <= 1'b0;
      start_q    <= 2'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          wall_rd <= 1'b0;
          if (start) begin
            x_q        <= x_pos;
            y_q        <= y_pos;
            dir_q      <= cur_dir;
            dist_q[0]  <= u_dist;
            dist_q[1]  <= l_dist;
            dist_q[2]  <= d_dist;
            dist_q[3]  <= r_dist;
            best_valid <= 1'b0;
            idx        <= 2'd0;
            busy       <= 1'b1;
            wall_rd    <= 1'b1;
            wall_addr  <= nb_addr;
            state      <= S_SCAN;
`ifdef GHOST_FRIGHT_RAND_EN
            fright_q   <= fright;
            start_q    <= lfsr[1:0];
`endif
          end
        end
        S_SCAN: begin
          if ((idx != 2'd0) && cand_take) begin
            best_valid <= 1'b1;
            best_dir   <= cand;
            best_key   <= cand_key;
          end
          if (idx == 2'd3) begin
            wall_rd <= 1'b0;
            state   <= S_LAST;
          end else begin
            idx       <= idx + 2'd1;
            wall_addr <= nb_addr;
          end
        end
        S_LAST: begin
          next_dir <= final_dir;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ghost_dir_select.md
Name: ghost_dir_select

Overview:
- Decision stage that consumes the four neighbour-tile distances produced by the ghost distance unit and commits the ghost's next move.
- Latches the distances on a start pulse, then scans the maze wall RAM for the four neighbour tiles.
- Discards walls and the reverse of the current heading, picks the minimum-distance legal direction, and returns it with a one-cycle done pulse.
- One instance per ghost, between the distance unit and the ghost movement controller.

Parameters:
- DIST_W, 11, width of each distance input.
- COORD_W, 5, width of one tile coordinate (maze is 32x32 tiles).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request pulse; ignored while busy=1
- x_pos  in  COORD_W  ghost tile column
- y_pos  in  COORD_W  ghost tile row
- cur_dir  in  2  current heading (dir_t)
- r_dist, l_dist, u_dist, d_dist  in  DIST_W each  squared distance to target from each neighbour tile
- fright  in  1  frightened mode; used only with the optional feature
- wall_rd  out  1  wall RAM read strobe
- wall_addr  out  2*COORD_W  wall RAM address {y,x}
- wall_data  in  1  wall bit; 1 = blocked; valid the cycle after wall_rd
- busy  out  1  high from the cycle after start until done, inclusive
- done  out  1  one-cycle pulse; next_dir valid
- next_dir  out  2  chosen direction; holds its value until the next done

Behaviour:
- Reset values: busy=0, done=0, wall_rd=0, wall_addr=0, next_dir=DIR_L, FSM=IDLE, LFSR=8'hA5.
- Asynchronous assertion of rst_n at any point, including mid-scan, aborts the scan. No done is issued.
- Start capture: start sampled high in IDLE latches x_pos, y_pos, cur_dir, fright and all four distances. Later changes on these inputs are ignored until done.
- Priority/scan order is fixed: idx0=DIR_U, idx1=DIR_L, idx2=DIR_D, idx3=DIR_R.
- Neighbour coordinates use COORD_W-bit modulo arithmetic, so tunnels wrap:
  - U = (x, y-1), D = (x, y+1), L = (x-1, y), R = (x+1, y).
  - Example: x=31 gives R column 0; y=0 gives U row 31.
- FSM states and transitions:
  - IDLE: on start -> SCAN with idx=0.
  - SCAN (4 cycles): wall_rd=1 and wall_addr = neighbour(idx). From idx>=1, evaluate candidate idx-1 using wall_data. After idx=3 -> LAST.
  - LAST (1 cycle): evaluate candidate 3 -> DONE.
  - DONE (1 cycle): done=1, next_dir updated -> IDLE.
- Timing: start high in cycle 0 gives done high in cycle 6. busy is high in cycles 1-6. A start in cycle 6 is ignored; the earliest accepted restart is cycle 7.
- Legal candidate: wall_data=0 and dir != (cur_dir ^ 2'b10).
- Selection: a legal candidate replaces the best only if its distance is strictly less, so on ties the earlier priority direction wins. Distances compare as unsigned DIST_W.
- Dead end (no legal candidate): next_dir = cur_dir ^ 2'b10 (reverse), even if that tile is a wall.
- wall_rd=0 in IDLE, LAST and DONE. wall_addr holds its last value.

Optional Feature:
- Macro: GHOST_FRIGHT_RAND_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle after reset.
  - If the latched fright=1, the distances are ignored. Selection starts at candidate LFSR[1:0] (sampled at start) and takes the first legal direction in cyclic order from there.
  - The dead-end rule is unchanged.
- Not defined: no LFSR is built and fright is ignored (no logic, no lint waiver beyond unused input).

Decomposition:
- Package ghost_pkg:
  - typedef enum logic[1:0] dir_t {DIR_U=0, DIR_L=1, DIR_D=2, DIR_R=3}; this encoding makes reverse = dir ^ 2'b10.
  - Constants COORD_W=5, DIST_W=11, MAZE_ADDR_W=10.
  - Function dir_reverse.
- One natural sub-module, tile_neighbour: combinational (x, y, dir) -> wrapped {y,x} address. The movement controller reuses it.

Test Plan:
- Open tile at (10,10), cur_dir=DIR_R, distances U=50, L=40, D=30, R=20, all walls 0 -> done in cycle 6, next_dir=DIR_R, busy high cycles 1-6.
- Same setup, cur_dir=DIR_L (reverse is R) -> next_dir=DIR_D (30).
- Tie: U=L=D=R=25, cur_dir=DIR_D -> next_dir=DIR_L. U is excluded as reverse; L wins the tie over R. Addresses observed in order U, L, D, R.
- Tunnel: x=31, y=14 -> wall_addr sequence {13,31}, {14,30}, {15,31}, {14,0}. With wall only at {14,0} and R smallest, R is skipped.
- Dead end: walls on all tiles except reverse, cur_dir=DIR_U -> next_dir=DIR_D. Also: start held during busy is ignored; rst_n low in cycle 3 -> no done, busy=0 immediately, next_dir=DIR_L.
- With GHOST_FRIGHT_RAND_EN, fright=1, all open, cur_dir=DIR_U: over 64 requests each legal dir (U, L, R) is chosen at least once, D never chosen.
